// File: rtl/serializador_contador_pkg.sv
// rtl/serializador_contador_pkg.sv - shared debug-unit types, widths and helpers
package serializador_contador_pkg;

  localparam int DATA_LENGTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  function automatic int num_bytes(input int contador_length, input int data_length);
    return (contador_length + data_length - 1) / data_length;
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// rtl/detector_flanco.sv - rising-edge detector for debug-unit request inputs
module detector_flanco (
  input  logic i_clock,
  input  logic i_soft_reset,
  input  logic level,
  output logic rise
);

  logic level_prev;

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      level_prev <= 1'b0;
    end else begin
      level_prev <= level;
    end
  end

  assign rise = level & ~level_prev;

endmodule

// File: rtl/serializador_contador.sv
// rtl/serializador_contador.sv - snapshots the cycle count and feeds it MSB-byte first to the UART TX
module serializador_contador
  import serializador_contador_pkg::*;
#(
  parameter int CONTADOR_LENGTH = 11,
  parameter int DATA_LENGTH     = DATA_LENGTH_DEFAULT
) (
  input  logic                       i_clock,
  input  logic                       i_soft_reset,
  input  logic                       i_request,
  input  logic [CONTADOR_LENGTH-1:0] i_cuenta,
  input  logic                       i_tx_done,
  output logic                       o_tx_start,
  output logic [DATA_LENGTH-1:0]     o_tx_data,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int NUM_BYTES = num_bytes(CONTADOR_LENGTH, DATA_LENGTH);
  localparam int SNAP_W    = NUM_BYTES * DATA_LENGTH;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_t                 state;
  state_t                 next_state;
  logic                   req_rise;
  logic [SNAP_W-1:0]      snapshot;
  logic [SNAP_W-1:0]      cuenta_ext;
  logic [IDX_W-1:0]       byte_idx;
  logic [DATA_LENGTH-1:0] tx_data;

  function automatic logic [DATA_LENGTH-1:0] byte_of(input logic [SNAP_W-1:0] value, input int idx);
    logic [SNAP_W-1:0] shifted;
    shifted = value >> (idx * DATA_LENGTH);
    return shifted[DATA_LENGTH-1:0];
  endfunction

  detector_flanco u_detector_flanco (
    .i_clock      (i_clock),
    .i_soft_reset (i_soft_reset),
    .level        (i_request),
    .rise         (req_rise)
  );

  assign cuenta_ext = SNAP_W'(i_cuenta);

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    o_tx_start = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (req_rise) next_state = START;
      end
      START: begin
        o_tx_start = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (i_tx_done) next_state = (byte_idx == '0) ? FINISH : START;
      end
      FINISH: begin
        o_done     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // tx_data is loaded on every entry to START so it stays stable through WAIT
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      snapshot <= '0;
      byte_idx <= '0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_rise) begin
            snapshot <= cuenta_ext;
            byte_idx <= IDX_W'(NUM_BYTES - 1);
            tx_data  <= byte_of(cuenta_ext, NUM_BYTES - 1);
          end
        end
        WAIT: begin
          if (i_tx_done && (byte_idx != '0)) begin
            byte_idx <= byte_idx - 1'b1;
            tx_data  <= byte_of(snapshot, int'(byte_idx) - 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_data = tx_data;

endmodule

// File: tb/tb_serializador_contador.sv
// tb/tb_serializador_contador.sv - randomized bench with a transaction-level reference model
module tb_serializador_contador;

  localparam int CL = 11;
  localparam int DL = 8;
  localparam int NB = 2;

  logic          i_clock = 1'b0;
  logic          i_soft_reset;
  logic          i_request;
  logic [CL-1:0] i_cuenta;
  logic          i_tx_done;
  logic          o_tx_start;
  logic [DL-1:0] o_tx_data;
  logic          o_busy;
  logic          o_done;

  always #5 i_clock = ~i_clock;

  serializador_contador #(.CONTADOR_LENGTH(CL), .DATA_LENGTH(DL)) dut (
    .i_clock      (i_clock),
    .i_soft_reset (i_soft_reset),
    .i_request    (i_request),
    .i_cuenta     (i_cuenta),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Stimulus knobs written only by the main sequence
  logic [CL-1:0] base = '0;
  bit inc_en = 0, noise_en = 0, stray_en = 0, rand_lat = 0;
  int lat = 3;

  // Reference model: a queue of bytes still owed to the UART plus the current phase
  bit        m_prev, m_start, m_wait, m_done;
  logic [7:0] m_data;
  logic [7:0] q[$];

  always @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      m_prev = 0; m_start = 0; m_wait = 0; m_done = 0; m_data = '0;
      q.delete();
    end else begin
      bit rise, idle, ns, nw, nd;
      rise = i_request && !m_prev;
      m_prev = i_request;
      idle = !(m_start || m_wait || m_done);
      ns = 0; nw = 0; nd = 0;
      if (m_start) begin
        nw = 1;
      end else if (m_wait) begin
        if (i_tx_done) begin
          void'(q.pop_front());
          if (q.size() == 0) nd = 1;
          else begin ns = 1; m_data = q[0]; end
        end else begin
          nw = 1;
        end
      end else if (idle && rise) begin
        q.delete();
        for (int i = NB - 1; i >= 0; i--) q.push_back(8'((i_cuenta >> (8 * i)) & 11'h0FF));
        ns = 1;
        m_data = q[0];
      end
      m_start = ns; m_wait = nw; m_done = nd;
    end
  end

  logic [7:0] sent[$];
  int done_cnt = 0;
  int busy_cyc = 0;

  always @(negedge i_clock) begin
    if (i_soft_reset === 1'b1) begin
      check("tx_start", {31'd0, o_tx_start}, {31'd0, m_start});
      check("busy", {31'd0, o_busy}, {31'd0, m_start | m_wait | m_done});
      check("done", {31'd0, o_done}, {31'd0, m_done});
      check("tx_data", {24'd0, o_tx_data}, {24'd0, m_data});
      if (o_tx_start) sent.push_back(o_tx_data);
      if (o_done) done_cnt++;
      if (o_busy) busy_cyc++;
    end
  end

  // UART TX model and count source: sole driver of i_tx_done and i_cuenta
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge i_clock);
      i_tx_done = 1'b0;
      if (inc_en) i_cuenta = i_cuenta + 1'b1;
      else i_cuenta = base;
      if (i_soft_reset !== 1'b1) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) i_tx_done = 1'b1;
        end else if (noise_en && $urandom_range(0, 7) == 0) begin
          i_tx_done = 1'b1;
        end
        if (stray_en && o_tx_start) i_tx_done = 1'b1;
        if (o_tx_start) cnt = rand_lat ? int'($urandom_range(1, 4)) : lat;
      end
    end
  end

  task automatic request_pulse();
    @(negedge i_clock);
    i_request = 1'b1;
    @(negedge i_clock);
    i_request = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d = done_cnt;
    int n = 0;
    while (done_cnt == d && n < 200) begin
      @(posedge i_clock);
      #2;
      n++;
    end
    if (done_cnt == d) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no o_done within %0d cycles", name, n);
    end
    repeat (2) @(negedge i_clock);
  endtask

  task automatic run_literal(input string name, input logic [CL-1:0] val, input logic [7:0] b1,
                             input logic [7:0] b0, input int l, input int busy_req);
    int s0, d0, c0;
    base = val;
    lat = l;
    @(negedge i_clock);
    s0 = sent.size(); d0 = done_cnt; c0 = busy_cyc;
    request_pulse();
    wait_done(name);
    check({name, "_nstart"}, sent.size() - s0, 2);
    check({name, "_byte_msb"}, {24'd0, sent[s0]}, {24'd0, b1});
    check({name, "_byte_lsb"}, {24'd0, sent[s0+1]}, {24'd0, b0});
    check({name, "_ndone"}, done_cnt - d0, 1);
    check({name, "_busy_cycles"}, busy_cyc - c0, busy_req);
  endtask

  initial begin
    int s0, d0;
    i_soft_reset = 1'b0;
    i_request = 1'b0;
    @(posedge i_clock);
    #1;
    check("reset_tx_start", {31'd0, o_tx_start}, 0);
    check("reset_busy", {31'd0, o_busy}, 0);
    check("reset_done", {31'd0, o_done}, 0);
    check("reset_tx_data", {24'd0, o_tx_data}, 0);
    repeat (2) @(negedge i_clock);
    #2 i_soft_reset = 1'b1;

    run_literal("basic", 11'h5A3, 8'h05, 8'hA3, 3, 9);

    // snapshot frozen while the count keeps running
    base = 11'h5A3;
    @(negedge i_clock);
    s0 = sent.size();
    @(negedge i_clock);
    i_request = 1'b1;
    @(negedge i_clock);
    i_request = 1'b0;
    inc_en = 1;
    wait_done("frozen");
    inc_en = 0;
    check("frozen_msb", {24'd0, sent[s0]}, 32'h05);
    check("frozen_lsb", {24'd0, sent[s0+1]}, 32'hA3);

    // held request: one transfer, then a fresh edge gives another
    s0 = sent.size(); d0 = done_cnt;
    @(negedge i_clock);
    i_request = 1'b1;
    repeat (50) @(negedge i_clock);
    i_request = 1'b0;
    check("held_ndone", done_cnt - d0, 1);
    check("held_nstart", sent.size() - s0, 2);
    request_pulse();
    wait_done("held_again");
    check("held_again_ndone", done_cnt - d0, 2);

    // request re-pulsed in WAIT and stray done in START are both ignored
    base = 11'h2C7;
    stray_en = 1;
    @(negedge i_clock);
    s0 = sent.size(); d0 = done_cnt;
    request_pulse();
    request_pulse();
    wait_done("busy_ignore");
    stray_en = 0;
    repeat (3) @(negedge i_clock);
    check("busy_ignore_nstart", sent.size() - s0, 2);
    check("busy_ignore_msb", {24'd0, sent[s0]}, 32'h02);
    check("busy_ignore_lsb", {24'd0, sent[s0+1]}, 32'hC7);
    check("busy_ignore_ndone", done_cnt - d0, 1);

    // asynchronous reset during the WAIT of the first byte
    base = 11'h5A3;
    @(negedge i_clock);
    s0 = sent.size(); d0 = done_cnt;
    request_pulse();
    @(negedge i_clock);
    @(posedge i_clock);
    #2 i_soft_reset = 1'b0;
    #1;
    check("midrst_tx_start", {31'd0, o_tx_start}, 0);
    check("midrst_busy", {31'd0, o_busy}, 0);
    check("midrst_done", {31'd0, o_done}, 0);
    check("midrst_tx_data", {24'd0, o_tx_data}, 0);
    repeat (2) @(negedge i_clock);
    #2 i_soft_reset = 1'b1;
    repeat (10) @(negedge i_clock);
    check("midrst_ndone", done_cnt - d0, 0);
    check("midrst_nstart", sent.size() - s0, 1);
    check("midrst_byte", {24'd0, sent[s0]}, 32'h05);

    run_literal("max", 11'h7FF, 8'h07, 8'hFF, 3, 9);
    run_literal("zero_min", 11'h000, 8'h00, 8'h00, 1, 5);

    // randomized traffic, every cycle checked against the model
    rand_lat = 1;
    noise_en = 1;
    for (int i = 0; i < 800; i++) begin
      @(negedge i_clock);
      i_request = ($urandom_range(0, 2) == 0);
      base = CL'($urandom);
    end
    i_request = 1'b0;
    noise_en = 0;
    repeat (40) @(negedge i_clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serializador_contador.md
# serializador_contador

Reader side of the cycle counter. On a rising edge of a request, it latches a snapshot of the running cycle count. It then splits the snapshot into UART-sized bytes and hands them one at a time to the UART transmitter, using a start/done handshake. It sits in the debug unit, between the cycle counter output and the UART TX.

## Interface

Reset: one clock; reset is asynchronous and active-low.

Parameters:
- `CONTADOR_LENGTH`, 11: width of the cycle count input.
- `DATA_LENGTH`, 8: UART byte width.
- `NUM_BYTES`, derived localparam = ceil(`CONTADOR_LENGTH`/`DATA_LENGTH`); 2 with defaults.

Ports:
- `i_clock`  in  1  system clock; all state changes on its rising edge.
- `i_soft_reset`  in  1  asynchronous, active-low reset.
- `i_request`  in  1  transfer request; only its 0→1 transition is acted on.
- `i_cuenta`  in  `CONTADOR_LENGTH`  live cycle count from the counter.
- `i_tx_done`  in  1  one-cycle pulse from the UART TX when a byte has been fully shifted out.
- `o_tx_start`  out  1  one-cycle pulse telling the UART TX to send `o_tx_data`.
- `o_tx_data`  out  `DATA_LENGTH`  byte currently offered to the UART TX.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse after the last byte's `i_tx_done`.

## Operation

- Request edge detect:
  - `req_prev` register, reset 0.
  - `req_rise = i_request & ~req_prev`.
- FSM states: IDLE, START, WAIT, FINISH.
- IDLE:
  - On `req_rise`, capture the snapshot: `i_cuenta` zero-extended to `NUM_BYTES*DATA_LENGTH` bits.
  - Set `byte_idx <= NUM_BYTES-1` and go to START.
  - Otherwise stay in IDLE.
- START:
  - `o_tx_start = 1`.
  - `o_tx_data` = snapshot byte `byte_idx`, where byte 0 is the least significant.
  - Unconditionally go to WAIT next cycle.
- WAIT:
  - `o_tx_data` is held stable.
  - On `i_tx_done`: if `byte_idx == 0`, go to FINISH; otherwise decrement `byte_idx` and go to START.
  - Without `i_tx_done`, stay in WAIT indefinitely; there is no timeout.
- FINISH: `o_done = 1` for this one cycle, then go to IDLE.
- Byte order on the wire is MSB-byte first.
- The snapshot is frozen for the whole transfer; changes on `i_cuenta` after capture have no effect.
- `i_request` edges while `o_busy` are ignored. There is no queueing. `req_prev` still tracks the input, so a level held high through FINISH does not retrigger.
- `i_tx_done` is ignored in IDLE, START and FINISH.
- Reset at any point, including mid-transfer:
  - State returns to IDLE.
  - `o_tx_start`, `o_busy` and `o_done` go to 0; `o_tx_data`, snapshot, `byte_idx` and `req_prev` go to 0.
  - No partial byte is reissued after reset.

## Timing

- Reset values: all outputs 0.
- Request edge: `i_request` rises before edge k, so `req_rise` is seen at edge k. In cycle k+1 (START): `o_busy = 1`, `o_tx_start = 1`, `o_tx_data` holds the MSB byte.
- `o_tx_start` is high for exactly one cycle per byte. Every `o_tx_start` is followed by at least one WAIT cycle.
- Between bytes: `i_tx_done` sampled at edge m gives the next START in cycle m+1.
- Completion: the last `i_tx_done` at edge m gives `o_done = 1` in cycle m+1 and `o_busy = 0` from cycle m+2.
- Minimum transfer length, with `i_tx_done` arriving on the first WAIT cycle: 2·`NUM_BYTES`+1 cycles from START to the end of FINISH.
- Earliest retrigger: a new transfer can start from a `req_rise` sampled in the first IDLE cycle after FINISH.

## Structure

- Shared debug package holds:
  - FSM state encoding: 2-bit localparams IDLE, START, WAIT, FINISH.
  - The `NUM_BYTES` ceiling-divide expression.
  - Default `DATA_LENGTH` = 8, shared with the UART.
- One sub-module, `detector_flanco`: a rising-edge detector with the same clock and reset. It is reused by other debug-unit request inputs.
- Byte selection is a mux on `byte_idx` over the snapshot register. `o_tx_data` is registered and loaded on entry to START.

## Test plan

- **Basic transfer:** `i_cuenta = 11'h5A3`, pulse `i_request`, UART model returns `i_tx_done` 3 cycles after each start. Required: `o_tx_data` 0x05 then 0xA3, two `o_tx_start` pulses, one `o_done`, total 9 cycles.
- **Snapshot frozen:** `i_cuenta` increments every cycle during the transfer. Required: bytes match the value captured at the request edge (0x05, 0xA3).
- **Held request:** `i_request` held high for 50 cycles. Required: exactly one transfer and one `o_done`. A second 0→1 edge after IDLE gives a second transfer.
- **Request and stray done while busy:** `i_request` re-pulsed during WAIT, and `i_tx_done` pulsed during START. Required: both ignored, byte sequence unchanged.
- **Reset mid-transfer:** assert `i_soft_reset = 0` asynchronously during the WAIT of byte 0x05. Required: all outputs 0 immediately, IDLE after release, and no `o_done`.
- **Extremes:** `i_cuenta = 11'h7FF`, then `11'h000`. Required: bytes 0x07,0xFF and 0x00,0x00.
